// File: rtl/otp_macro_cmd_responder.sv
// rtl/otp_macro_cmd_responder.sv - behavioural OTP macro responder executing fuse_ctrl commands on an internal fuse array
// Optional ECC fault-injection inputs are enabled by defining OTP_MACRO_RESP_FAULT_INJ_EN.
module otp_macro_cmd_responder #(
    parameter int OtpWidth     = 16,
    parameter int OtpAddrWidth = 10,
    parameter int OtpDepth     = 1024,
    parameter int OtpSizeWidth = 2,
    parameter int OtpIfWidth   = (2 ** OtpSizeWidth) * OtpWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [2:0]              cmd_i,
    input  logic [OtpSizeWidth-1:0] size_i,
    input  logic [OtpAddrWidth-1:0] addr_i,
    input  logic [OtpIfWidth-1:0]   wdata_i,
`ifdef OTP_MACRO_RESP_FAULT_INJ_EN
    input  logic                    inj_corr_i,
    input  logic                    inj_uncorr_i,
`endif
    output logic                    valid_o,
    output logic [OtpIfWidth-1:0]   rdata_o,
    output logic [2:0]              err_o,
    output logic                    init_done_o
);

    localparam logic [2:0] CmdRead  = 3'd0;
    localparam logic [2:0] CmdWrite = 3'd1;
    localparam logic [2:0] CmdInit  = 3'd2;
    localparam logic [2:0] CmdZero  = 3'd3;

    localparam logic [2:0] ErrNone       = 3'd0;
    localparam logic [2:0] ErrMacro      = 3'd1;
    localparam logic [2:0] ErrEccCorr    = 3'd2;
    localparam logic [2:0] ErrEccUncorr  = 3'd3;
    localparam logic [2:0] ErrWriteBlank = 3'd4;

    typedef enum logic [1:0] {
        ResetSt,
        IdleSt,
        ExecSt,
        RespSt
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              cmd_q, cmd_d;
    logic [OtpSizeWidth-1:0] size_q, size_d;
    logic [OtpAddrWidth-1:0] addr_q, addr_d;
    logic [OtpIfWidth-1:0]   wdata_q, wdata_d;
    logic [OtpSizeWidth-1:0] k_q, k_d;
    logic [OtpIfWidth-1:0]   rdata_q, rdata_d;
    logic [2:0]              err_q, err_d;
    logic                    init_done_q, init_done_d;
    logic                    inj_corr_q, inj_corr_d;
    logic                    inj_uncorr_q, inj_uncorr_d;

    // Fuse array: deliberately outside the reset domain, fuses survive rst_i.
    logic [OtpWidth-1:0]     mem_q [OtpDepth];

    logic                    mem_we;
    logic [OtpWidth-1:0]     mem_wdata;
    logic [OtpAddrWidth-1:0] word_addr;
    logic [OtpWidth-1:0]     cur_word;
    logic [OtpWidth-1:0]     wr_word;
    logic [31:0]             end_addr;
    logic                    precheck_err;
    logic                    inj_corr;
    logic                    inj_uncorr;

`ifdef OTP_MACRO_RESP_FAULT_INJ_EN
    assign inj_corr   = inj_corr_i;
    assign inj_uncorr = inj_uncorr_i;
`else
    assign inj_corr   = 1'b0;
    assign inj_uncorr = 1'b0;
`endif

    assign end_addr     = 32'(addr_i) + 32'(size_i);
    assign precheck_err = (cmd_i > CmdZero) ||
                          ((cmd_i != CmdInit) && (!init_done_q || (end_addr >= 32'(OtpDepth))));

    assign word_addr = addr_q + OtpAddrWidth'(k_q);
    assign cur_word  = mem_q[word_addr];
    assign wr_word   = wdata_q[32'(k_q) * OtpWidth +: OtpWidth];

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        k_d          = k_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        init_done_d  = init_done_q;
        inj_corr_d   = inj_corr_q;
        inj_uncorr_d = inj_uncorr_q;
        mem_we       = 1'b0;
        mem_wdata    = cur_word;

        unique case (state_q)
            ResetSt: state_d = IdleSt;

            IdleSt: begin
                if (valid_i) begin
                    cmd_d        = cmd_i;
                    size_d       = size_i;
                    addr_d       = addr_i;
                    wdata_d      = wdata_i;
                    inj_corr_d   = inj_corr;
                    inj_uncorr_d = inj_uncorr;
                    k_d          = '0;
                    rdata_d      = '0;
                    err_d        = ErrNone;
                    if (precheck_err) begin
                        err_d   = ErrMacro;
                        state_d = RespSt;
                    end else if (cmd_i == CmdInit) begin
                        init_done_d = 1'b1;
                        state_d     = RespSt;
                    end else begin
                        state_d = ExecSt;
                    end
                end
            end

            ExecSt: begin
                case (cmd_q)
                    CmdRead: rdata_d[32'(k_q) * OtpWidth +: OtpWidth] = cur_word;
                    CmdWrite: begin
                        // A bit already blown that the new word wants at 0 cannot be honoured.
                        if (|(cur_word & ~wr_word)) begin
                            err_d = ErrWriteBlank;
                        end else begin
                            mem_we    = 1'b1;
                            mem_wdata = cur_word | wr_word;
                        end
                    end
                    CmdZero: begin
                        mem_we    = 1'b1;
                        mem_wdata = '1;
                        rdata_d[32'(k_q) * OtpWidth +: OtpWidth] = '1;
                    end
                    default: ;
                endcase

                if (k_q == size_q) begin
                    state_d = RespSt;
                    if ((cmd_q == CmdRead) && inj_uncorr_q) begin
                        rdata_d = '0;
                        err_d   = ErrEccUncorr;
                    end else if ((cmd_q == CmdRead) && inj_corr_q) begin
                        err_d = ErrEccCorr;
                    end
                end else begin
                    k_d = k_q + OtpSizeWidth'(1);
                end
            end

            RespSt: state_d = IdleSt;

            default: state_d = ResetSt;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ResetSt;
            cmd_q        <= '0;
            size_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            k_q          <= '0;
            rdata_q      <= '0;
            err_q        <= ErrNone;
            init_done_q  <= 1'b0;
            inj_corr_q   <= 1'b0;
            inj_uncorr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            k_q          <= k_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            init_done_q  <= init_done_d;
            inj_corr_q   <= inj_corr_d;
            inj_uncorr_q <= inj_uncorr_d;
        end
    end

    // A reset arriving mid-burst must not program the word in flight.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem_q[word_addr] <= mem_wdata;
        end
    end

    assign ready_o     = (state_q == IdleSt);
    assign valid_o     = (state_q == RespSt);
    assign rdata_o     = valid_o ? rdata_q : '0;
    assign err_o       = valid_o ? err_q : ErrNone;
    assign init_done_o = init_done_q;

endmodule
